bcd_digit_scanner: RTL and testbench

Time-multiplexed scan controller for a multi-digit 7-segment display. Holds a packed word of BCD digits and presents one digit at a time on bcd_out, with a one-hot digit select, at a programmable refresh rate. Sits directly upstream of the BCD-to-segment decoder: bcd_out drives the decoder input, and digit_sel drives the display common lines. New values are double-buffered and committed only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/bcd_digit_scanner.sv | 199 +++++++++++++++++++
 tb/tb_bcd_digit_scanner.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_digit_scanner.sv
// -----------------------------------------------------------------------------
// bcd_digit_scanner
//
// Time-multiplexed scan controller for a multi-digit 7-segment display.
// A packed word of BCD digits is shown one digit at a time: bcd_out feeds the
// BCD-to-segment decoder and digit_sel drives the display common lines.
// New values are double-buffered. load captures into a shadow register, and
// the shadow is copied to the active register only at a frame boundary. This
// means a frame never mixes old and new digits.
//
// Parameters:
//   NUM_DIGITS   number of digits scanned (2..8)
//   REFRESH_DIV  clock cycles each digit stays selected (>= 1)
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   load        one-cycle strobe, captures digits_in into the shadow register
//   digits_in   packed BCD, nibble 0 (LSBs) is the units digit
//   bcd_out     BCD of the currently selected digit (registered)
//   digit_sel   one-hot active-high digit enable, all zero when blanked
//   blank       current digit is blanked
//   frame_tick  one-cycle pulse after every completed frame
//   load_ack    one-cycle pulse after the shadow was committed to active
//
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, leading zero digits (never digit 0)
//                          are blanked. When undefined, blank is constant 0
//                          and digit_sel is always one-hot.
// -----------------------------------------------------------------------------
module bcd_digit_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    blank,
  output logic                    frame_tick,
  output logic                    load_ack
);

  // Keep the prescaler at least one bit wide so that REFRESH_DIV=1 still
  // elaborates. In that case the counter stays at 0 and every cycle is an
  // advance edge.
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PW-1:0]         presc_q,      presc_d;
  logic [IW-1:0]         idx_q,        idx_d;
  logic [DW-1:0]         active_q,     active_d;
  logic [DW-1:0]         shadow_q,     shadow_d;
  logic                  pending_q,    pending_d;
  logic [3:0]            bcd_out_q,    bcd_out_d;
  logic [NUM_DIGITS-1:0] digit_sel_q,  digit_sel_d;
  logic                  blank_q,      blank_d;
  logic                  frame_tick_q, frame_tick_d;
  logic                  load_ack_q,   load_ack_d;

  logic advance;
  logic wrap;

  // ---------------------------------------------------------------------------
  // Prescaler and digit index
  // ---------------------------------------------------------------------------
  assign advance = (presc_q == PRESC_LAST);
  assign wrap    = advance && (idx_q == IDX_LAST);

  always_comb begin
    presc_d = presc_q + PW'(1);
    if (advance) begin
      presc_d = '0;
    end
  end

  always_comb begin
    idx_d = idx_q;
    if (wrap) begin
      idx_d = '0;
    end else if (advance) begin
      idx_d = idx_q + IW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Double buffer
  //
  // The commit on a wrap edge always uses the shadow as it was before that
  // edge. A load arriving on the same edge refills the shadow and keeps
  // pending set, so it is committed at the following wrap.
  // ---------------------------------------------------------------------------
  always_comb begin
    active_d = active_q;
    if (wrap && pending_q) begin
      active_d = shadow_q;
    end
  end

  always_comb begin
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (load) begin
      shadow_d  = digits_in;
      pending_d = 1'b1;
    end else if (wrap) begin
      pending_d = 1'b0;
    end
  end

  assign frame_tick_d = wrap;
  assign load_ack_d   = wrap && pending_q;

  // ---------------------------------------------------------------------------
  // Display outputs
  //
  // These outputs are computed from the next-state index and active word. As a
  // result, the registered outputs change on the same edge as idx. A
  // committing wrap edge therefore already shows digit 0 of the new value.
  // ---------------------------------------------------------------------------
  logic [3:0]            nib_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] onehot_d;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign nib_d[gi]    = active_d[4*gi +: 4];
    assign onehot_d[gi] = (idx_d == IW'(gi));
  end

  assign bcd_out_d = nib_d[idx_d];

`ifdef LEADING_ZERO_BLANK_EN
  // zero_above_d[i] is set when nibbles NUM_DIGITS-1 down to i are all zero.
  // The loop is written as a running AND, which avoids a self-referencing
  // vector.
  logic [NUM_DIGITS-1:0] zero_above_d;
  logic                  zero_run;

  always_comb begin
    zero_above_d = '0;
    zero_run     = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run        = zero_run && (nib_d[i] == 4'd0);
      zero_above_d[i] = zero_run;
    end
  end

  // Digit 0 is always lit, so a value of zero still shows a single "0".
  assign blank_d     = (idx_d != '0) && zero_above_d[idx_d];
  assign digit_sel_d = blank_d ? '0 : onehot_d;
`else
  assign blank_d     = 1'b0;
  assign digit_sel_d = onehot_d;
`endif

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      active_q     <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      bcd_out_q    <= 4'd0;
      digit_sel_q  <= NUM_DIGITS'(1);
      blank_q      <= 1'b0;
      frame_tick_q <= 1'b0;
      load_ack_q   <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      bcd_out_q    <= bcd_out_d;
      digit_sel_q  <= digit_sel_d;
      blank_q      <= blank_d;
      frame_tick_q <= frame_tick_d;
      load_ack_q   <= load_ack_d;
    end
  end

  assign bcd_out    = bcd_out_q;
  assign digit_sel  = digit_sel_q;
  assign blank      = blank_q;
  assign frame_tick = frame_tick_q;
  assign load_ack   = load_ack_q;

endmodule

// File: tb/tb_bcd_digit_scanner.sv
// -----------------------------------------------------------------------------
// tb_bcd_digit_scanner
//
// Instance u_dut runs with NUM_DIGITS=4 and REFRESH_DIV=4. Every cycle, it is
// compared against a cycle-count based reference model. The bench also checks
// it with a table of display patterns and with hand-written wrap-edge
// sequences.
//
// Instance u_dut1 runs with REFRESH_DIV=1. It covers the mid-frame reset case
// and the per-cycle rotation.
// -----------------------------------------------------------------------------
module tb_bcd_digit_scanner;

  localparam int ND    = 4;
  localparam int RD    = 4;
  localparam int FRAME = ND * RD;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 0 (REFRESH_DIV = 4)
  logic        rst_n = 1'b0;
  logic        load  = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  bcd_out;
  logic [3:0]  digit_sel;
  logic        blank;
  logic        frame_tick;
  logic        load_ack;

  // DUT 1 (REFRESH_DIV = 1)
  logic        rst_n1 = 1'b0;
  logic        load1  = 1'b0;
  logic [15:0] digits_in1 = '0;
  logic [3:0]  bcd_out1;
  logic [3:0]  digit_sel1;
  logic        blank1;
  logic        frame_tick1;
  logic        load_ack1;

  bcd_digit_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .digits_in  (digits_in),
    .bcd_out    (bcd_out),
    .digit_sel  (digit_sel),
    .blank      (blank),
    .frame_tick (frame_tick),
    .load_ack   (load_ack)
  );

  bcd_digit_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(1)) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n1),
    .load       (load1),
    .digits_in  (digits_in1),
    .bcd_out    (bcd_out1),
    .digit_sel  (digit_sel1),
    .blank      (blank1),
    .frame_tick (frame_tick1),
    .load_ack   (load_ack1)
  );

  int errors = 0;
  int checks = 0;
  int ack_seen = 0;
  int ft_seen  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model.
  //
  // m_k counts clock edges since reset release. The displayed digit is
  // (k / RD) % ND. A frame ends on every edge where k is a multiple of FRAME.
  // ---------------------------------------------------------------------------
  int          m_k = 0;
  logic [15:0] m_active  = '0;
  logic [15:0] m_shadow  = '0;
  logic        m_pending = 1'b0;
  logic        m_ft  = 1'b0;
  logic        m_ack = 1'b0;

  task automatic model_step(input logic r, input logic ld, input logic [15:0] d);
    logic is_wrap;
    if (!r) begin
      m_k = 0; m_active = '0; m_shadow = '0; m_pending = 1'b0;
      m_ft = 1'b0; m_ack = 1'b0;
    end else begin
      m_k++;
      is_wrap = (m_k % FRAME) == 0;
      m_ft  = is_wrap;
      m_ack = is_wrap && m_pending;
      if (is_wrap && m_pending) m_active = m_shadow;
      if (ld) begin
        m_shadow = d; m_pending = 1'b1;
      end else if (is_wrap) begin
        m_pending = 1'b0;
      end
    end
  endtask

  task automatic model_compare();
    int          idx;
    logic [15:0] upper;
    logic        exp_blank;
    logic [3:0]  exp_sel;
    idx   = (m_k / RD) % ND;
    upper = m_active >> (4 * idx);
`ifdef LEADING_ZERO_BLANK_EN
    exp_blank = (idx != 0) && (upper == 16'd0);
`else
    exp_blank = 1'b0;
`endif
    exp_sel = exp_blank ? 4'd0 : 4'(1 << idx);
    chk("model_bcd_out",    bcd_out,    upper[3:0]);
    chk("model_digit_sel",  digit_sel,  exp_sel);
    chk("model_blank",      blank,      exp_blank);
    chk("model_frame_tick", frame_tick, m_ft);
    chk("model_load_ack",   load_ack,   m_ack);
  endtask

  // One clock cycle on DUT 0: drive, clock, update the model, compare.
  task automatic tick(input logic r, input logic ld, input logic [15:0] d);
    rst_n = r; load = ld; digits_in = d;
    @(posedge clk);
    model_step(r, ld, d);
    #1;
    if (load_ack)   ack_seen++;
    if (frame_tick) ft_seen++;
    model_compare();
    load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 16'h0);
  endtask

  // Advance until the edge just taken was a wrap edge (bounded by one frame).
  task automatic run_to_wrap();
    for (int i = 0; i < FRAME && (m_k % FRAME) != 0; i++) tick(1'b1, 1'b0, 16'h0);
  endtask

  // Advance until the next edge will be a wrap edge.
  task automatic run_to_pre_wrap();
    for (int i = 0; i < FRAME && ((m_k + 1) % FRAME) != 0; i++) tick(1'b1, 1'b0, 16'h0);
  endtask

  // One clock cycle on DUT 1.
  task automatic tick1(input logic r, input logic ld, input logic [15:0] d);
    rst_n1 = r; load1 = ld; digits_in1 = d;
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Display pattern table. sel packs the expected digit_sel of digit d in
  // nibble d. bcd packs the expected bcd_out of digit d in nibble d.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [15:0] value;
    logic [15:0] bcd;
    logic [15:0] sel;
  } pattern_t;

  pattern_t tbl [5];

  initial begin
    int a0;
    logic [15:0] s;
    logic [15:0] b;

    tbl[0] = '{value: 16'h1234, bcd: 16'h1234, sel: 16'h8421};
    tbl[1] = '{value: 16'hFEDC, bcd: 16'hFEDC, sel: 16'h8421};
`ifdef LEADING_ZERO_BLANK_EN
    tbl[2] = '{value: 16'h0050, bcd: 16'h0050, sel: 16'h0021};
    tbl[3] = '{value: 16'h0000, bcd: 16'h0000, sel: 16'h0001};
    tbl[4] = '{value: 16'h0301, bcd: 16'h0301, sel: 16'h0421};
`else
    tbl[2] = '{value: 16'h0050, bcd: 16'h0050, sel: 16'h8421};
    tbl[3] = '{value: 16'h0000, bcd: 16'h0000, sel: 16'h8421};
    tbl[4] = '{value: 16'h0301, bcd: 16'h0301, sel: 16'h8421};
`endif

    // --- Reset held with load asserted: the load must be ignored ------------
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 16'h1234);
    chk("reset_sel",  digit_sel,  4'b0001);
    chk("reset_bcd",  bcd_out,    4'd0);
    chk("reset_ack",  load_ack,   1'b0);
    chk("reset_tick", frame_tick, 1'b0);
    run(FRAME);
    chk("first_frame_no_ack",   ack_seen, 0);
    chk("first_frame_one_tick", ft_seen,  1);

    // --- Table: load mid-frame, then check every digit of the next frame -----
    for (int t = 0; t < 5; t++) begin
      run(2);
      tick(1'b1, 1'b1, tbl[t].value);
      run_to_wrap();
      chk("tbl_ack_at_wrap",  load_ack,   1'b1);
      chk("tbl_tick_at_wrap", frame_tick, 1'b1);
      s = tbl[t].sel;
      b = tbl[t].bcd;
      for (int d = 0; d < ND; d++) begin
        chk("tbl_sel",   digit_sel, s[4*d +: 4]);
        chk("tbl_bcd",   bcd_out,   b[4*d +: 4]);
        chk("tbl_blank", blank,     s[4*d +: 4] == 4'd0);
        run(RD);
      end
    end

    // --- Two loads in one frame: only the last is committed, with one ack ---
    a0 = ack_seen;
    run(1);
    tick(1'b1, 1'b1, 16'h5678);
    run(3);
    tick(1'b1, 1'b1, 16'h9012);
    run_to_wrap();
    chk("double_load_bcd0", bcd_out, 4'h2);
    run(FRAME);
    chk("double_load_one_ack", ack_seen, a0 + 1);

    // --- Load on the wrap edge: old shadow commits, new one waits a frame ---
    run(1);
    tick(1'b1, 1'b1, 16'hAAAA);
    run_to_pre_wrap();
    a0 = ack_seen;
    tick(1'b1, 1'b1, 16'h3333);
    chk("wrap_load_ack1", load_ack,  1'b1);
    chk("wrap_load_bcdA", bcd_out,   4'hA);
    chk("wrap_load_sel",  digit_sel, 4'b0001);
    run(FRAME - 1);
    chk("wrap_load_still_A", bcd_out, 4'hA);
    tick(1'b1, 1'b0, 16'h0);
    chk("wrap_load_ack2", load_ack, 1'b1);
    chk("wrap_load_bcd3", bcd_out,  4'h3);
    chk("wrap_load_acks", ack_seen, a0 + 2);

    // --- Randomized traffic against the model --------------------------------
    for (int i = 0; i < 1500; i++) begin
      logic        r;
      logic        ld;
      logic [15:0] d;
      r  = ($urandom_range(0, 199) != 0);
      ld = ($urandom_range(0, 7) == 0);
      d  = 16'($urandom);
      d  = d >> (4 * $urandom_range(0, 3));
      tick(r, ld, d);
    end

    // --- REFRESH_DIV = 1: reset at idx 2 discards the pending load -----------
    tick1(1'b0, 1'b0, 16'h0);
    tick1(1'b1, 1'b1, 16'h4321);   // idx 1, load captured
    chk("rd1_sel_idx1", digit_sel1, 4'b0010);
    tick1(1'b1, 1'b0, 16'h0);      // idx 2
    chk("rd1_sel_idx2", digit_sel1, 4'b0100);
    tick1(1'b0, 1'b0, 16'h0);      // reset mid-frame
    chk("rd1_reset_sel",  digit_sel1,  4'b0001);
    chk("rd1_reset_ack",  load_ack1,   1'b0);
    chk("rd1_reset_tick", frame_tick1, 1'b0);
    tick1(1'b1, 1'b0, 16'h0);
    chk("rd1_rot1", digit_sel1, 4'b0010);
    tick1(1'b1, 1'b0, 16'h0);
    chk("rd1_rot2", digit_sel1, 4'b0100);
    tick1(1'b1, 1'b0, 16'h0);
    chk("rd1_rot3", digit_sel1, 4'b1000);
    chk("rd1_no_tick_mid", frame_tick1, 1'b0);
    tick1(1'b1, 1'b0, 16'h0);      // wrap edge
    chk("rd1_rot0",      digit_sel1,  4'b0001);
    chk("rd1_wrap_tick", frame_tick1, 1'b1);
    chk("rd1_wrap_noack", load_ack1,  1'b0);
    chk("rd1_wrap_bcd",  bcd_out1,    4'd0);
    tick1(1'b1, 1'b0, 16'h0);
    chk("rd1_tick_pulse_len", frame_tick1, 1'b0);
    chk("rd1_rot1b", digit_sel1, 4'b0010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
